// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- UART transmitter with an integrated transmit FIFO and bit-rate divider.
//
// Words arrive over a valid/ready handshake and are buffered in a FIFO_DEPTH-entry FIFO.
// Each word is sent as a frame:
//   start bit (0), DATA_BITS data bits (LSB first), optional parity bit, one or two stop bits (1).
// Each bit lasts baud_div+1 clock cycles. baud_div, stop2 and parity_odd are captured at the
// start of each frame, so changing them mid-frame does not affect the frame on the line.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the data bits.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   baud_div    clock cycles per bit minus 1
//   stop2       1 = two stop bits, 0 = one stop bit
//   parity_odd  1 = odd parity, 0 = even parity (used only with UART_TX_PARITY_EN)
//   s_data      word to transmit
//   s_valid     s_data is valid
//   s_ready     FIFO can accept a word (!full)
//   TXD         serial line, idle high
//   busy        a frame is on the line
//   fifo_count  current FIFO occupancy
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic                          stop2,
  input  logic                          parity_odd,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          TXD,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 push, pop, empty;
  logic [DATA_BITS-1:0] head;

  // Serialiser state
  state_t               state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 stop2_q, stop2_d;
  logic                 stop_q, stop_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 txd_q, txd_d;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`else
  logic                 unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  assign s_ready    = (count_q != CW'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign push       = s_valid && s_ready;
  assign head       = mem_q[rd_ptr_q];
  assign TXD        = txd_q;
  assign busy       = (state_q != S_IDLE);
  assign fifo_count = count_q;
  assign bit_end    = (cnt_q == '0);

  // FIFO bookkeeping; pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  // Next-state logic. A frame starts (and pops the FIFO) either from IDLE or at the end of
  // the last stop bit, which gives back-to-back frames without an idle gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    stop2_d = stop2_q;
    stop_d  = stop_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!empty) pop = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = div_q;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = div_q;
          shreg_d = shreg_q >> 1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = div_q;
          stop_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_q) begin
            stop_d = 1'b1;
            cnt_d  = div_q;
          end else if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame start: capture the head word and the per-frame line settings.
    if (pop) begin
      state_d = S_START;
      cnt_d   = baud_div;
      div_d   = baud_div;
      stop2_d = stop2;
      stop_d  = 1'b0;
      shreg_d = head;
`ifdef UART_TX_PARITY_EN
      par_d   = (^head) ^ parity_odd;
`endif
    end

    // TXD is registered from the next state so the pad sees a clean flop output.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      stop2_q  <= 1'b0;
      stop_q   <= 1'b0;
      bit_q    <= '0;
      shreg_q  <= '0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      stop2_q  <= stop2_d;
      stop_q   <= stop_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: a queue-based frame model checked every cycle against the
// main instance (DATA_BITS=8, FIFO_DEPTH=8), plus literal waveform checks, and a second
// instance with DATA_BITS=5.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] baud_div;
  logic        stop2;
  logic        parity_odd;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        TXD;
  logic        busy;
  logic [3:0]  fifo_count;

  logic [15:0] baud_div5;
  logic [4:0]  s_data5;
  logic        s_valid5;
  logic        s_ready5;
  logic        TXD5;
  logic        busy5;
  logic [2:0]  fifo_count5;

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(8), .DIV_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .stop2(stop2), .parity_odd(parity_odd),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .TXD(TXD), .busy(busy),
    .fifo_count(fifo_count)
  );

  uart_tx_fifo #(.DATA_BITS(5), .FIFO_DEPTH(4), .DIV_W(16)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div5), .stop2(1'b0), .parity_odd(1'b0),
    .s_data(s_data5), .s_valid(s_valid5), .s_ready(s_ready5), .TXD(TXD5), .busy(busy5),
    .fifo_count(fifo_count5)
  );

`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Behavioural model ----------------
  // mq holds words waiting in the FIFO; mline holds the exact TXD value for each future
  // cycle of the frame currently being sent. A new frame starts when the line queue is
  // empty and a word is waiting.
  logic [7:0] mq[$];
  logic       mline[$];
  logic       m_txd  = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_full;
  logic [7:0] m_word;

  function automatic void build_frame(input logic [7:0] w);
    logic fb[$];
    fb.push_back(1'b0);
    for (int i = 0; i < 8; i++) fb.push_back(w[i]);
`ifdef UART_TX_PARITY_EN
    fb.push_back((^w) ^ parity_odd);
`endif
    fb.push_back(1'b1);
    if (stop2) fb.push_back(1'b1);
    foreach (fb[i])
      for (int r = 0; r <= int'(baud_div); r++) mline.push_back(fb[i]);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        mline.delete();
        m_txd  = 1'b1;
        m_busy = 1'b0;
      end else begin
        m_full = (mq.size() >= 8);
        if (mline.size() == 0 && mq.size() != 0) begin
          m_word = mq.pop_front();
          build_frame(m_word);
        end
        if (mline.size() != 0) begin
          m_txd  = mline.pop_front();
          m_busy = 1'b1;
        end else begin
          m_txd  = 1'b1;
          m_busy = 1'b0;
        end
        if (s_valid && !m_full) mq.push_back(s_data);
      end
    end
  end

  // Per-cycle comparison of the main instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("txd",        32'(TXD),        32'(m_txd));
      check("busy",       32'(busy),       32'(m_busy));
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
      check("s_ready",    32'(s_ready),    32'(mq.size() < 8));
    end
  end

  // ---------------- Stimulus helpers ----------------
  logic cap [128];
  logic capb[128];
  logic cap5 [128];
  logic capb5[128];

  task automatic push(input logic [7:0] w);
    s_valid = 1'b1;
    s_data  = w;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // cap[0] is the first cycle after the edge that follows the push edge (start bit).
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap[i]   = TXD;
      capb[i]  = busy;
      cap5[i]  = TXD5;
      capb5[i] = busy5;
    end
  endtask

  task automatic wait_idle(input int lim, input string name);
    int k = 0;
    while ((busy !== 1'b0 || fifo_count !== 4'd0) && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(k < lim), 32'd1);
  endtask

  logic [9:0]  e_a5;
  logic [10:0] e_par;
  logic [7:0]  e5;
  int          nb5;
  logic        e_b2b;

  initial begin
    rst_n      = 1'b0;
    baud_div   = 16'd3;
    stop2      = 1'b0;
    parity_odd = 1'b0;
    s_data     = 8'h00;
    s_valid    = 1'b0;
    baud_div5  = 16'd1;
    s_data5    = 5'h00;
    s_valid5   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd",     32'(TXD),        32'd1);
    check("rst_busy",    32'(busy),       32'd0);
    check("rst_s_ready", 32'(s_ready),    32'd1);
    check("rst_count",   32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame: 0xA5, 4 cycles per bit, one stop bit, 40 cycles total (44 with parity).
    push(8'hA5);
    capture(41 + 4 * PBITS);
    e_a5 = 10'b1101001010;
    for (int i = 0; i < 9; i++)
      for (int k = 0; k < 4; k++)
        check("a5_bit", 32'(cap[4*i+k]), 32'(e_a5[i]));
    for (int k = 0; k < 4; k++)
      check("a5_stop", 32'(cap[4*(9+PBITS)+k]), 32'd1);
    check("a5_busy_last", 32'(capb[39 + 4*PBITS]), 32'd1);
    check("a5_busy_end",  32'(capb[40 + 4*PBITS]), 32'd0);
    wait_idle(200, "idle_a5");

`ifdef UART_TX_PARITY_EN
    // Parity bits: A5 even -> 0, 07 odd -> 0, 07 even -> 1; frames 44 cycles.
    e_par = 11'b00000000_010;
    parity_odd = 1'b0; push(8'hA5); capture(45);
    check("par_a5_even", 32'(cap[37]), 32'd0);
    check("par_a5_len",  32'(capb[44]), 32'd0);
    parity_odd = 1'b1; push(8'h07); capture(45);
    check("par_07_odd",  32'(cap[37]), 32'd0);
    check("par_07_len",  32'(capb[43]), 32'd1);
    parity_odd = 1'b0; push(8'h07); capture(45);
    check("par_07_even", 32'(cap[37]), 32'(e_par[1]));
    wait_idle(200, "idle_par");
`endif

    // Back-to-back, two stop bits, one cycle per bit.
    stop2    = 1'b1;
    baud_div = 16'd0;
    s_valid  = 1'b1;
    s_data   = 8'h00;
    @(negedge clk);
    s_data   = 8'hFF;
    @(negedge clk);
    s_valid  = 1'b0;
    cap[0]   = TXD;
    capb[0]  = busy;
    for (int i = 1; i < 23 + 2*PBITS; i++) begin
      @(negedge clk);
      cap[i]  = TXD;
      capb[i] = busy;
    end
    if (PBITS == 0) begin
      for (int i = 0; i < 22; i++) begin
        e_b2b = (i < 9) ? 1'b0 : (i < 11) ? 1'b1 : (i == 11) ? 1'b0 : 1'b1;
        check("b2b_bit", 32'(cap[i]), 32'(e_b2b));
      end
    end
    check("b2b_second_start", 32'(cap[11 + PBITS]), 32'd0);
    check("b2b_busy_end",     32'(capb[22 + 2*PBITS]), 32'd0);
    wait_idle(200, "idle_b2b");

    // Full FIFO: hold s_valid for 10 words; only 9 fit (one is popped immediately).
    stop2    = 1'b0;
    baud_div = 16'd2;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h30 + i);
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("full_count",   32'(fifo_count), 32'd8);
    check("full_s_ready", 32'(s_ready),    32'd0);
    wait_idle(1000, "idle_full");

    // Reset mid-frame with words queued.
    baud_div = 16'd3;
    s_valid  = 1'b1;
    s_data   = 8'h11;
    @(negedge clk);
    s_data   = 8'h22;
    @(negedge clk);
    s_data   = 8'h33;
    @(negedge clk);
    s_valid  = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_txd",     32'(TXD),        32'd1);
    check("mid_rst_busy",    32'(busy),       32'd0);
    check("mid_rst_count",   32'(fifo_count), 32'd0);
    check("mid_rst_s_ready", 32'(s_ready),    32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_txd",  32'(TXD),  32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    // DATA_BITS=5 instance, 2 cycles per bit.
    nb5 = 7 + PBITS;
    s_valid5 = 1'b1;
    s_data5  = 5'h1F;
    @(negedge clk);
    s_valid5 = 1'b0;
    capture(2*nb5 + 1);
`ifdef UART_TX_PARITY_EN
    e5 = 8'b11111110;
`else
    e5 = 8'b01111110;
`endif
    for (int i = 0; i < nb5; i++) begin
      check("d5_1f_bit", 32'(cap5[2*i]),   32'(e5[i]));
      check("d5_1f_bit", 32'(cap5[2*i+1]), 32'(e5[i]));
    end
    check("d5_1f_busy_end", 32'(capb5[2*nb5]), 32'd0);
    s_valid5 = 1'b1;
    s_data5  = 5'h12;
    @(negedge clk);
    s_valid5 = 1'b0;
    capture(2*nb5 + 1);
`ifdef UART_TX_PARITY_EN
    e5 = 8'b10100100;
`else
    e5 = 8'b01100100;
`endif
    for (int i = 0; i < nb5; i++)
      check("d5_12_bit", 32'(cap5[2*i+1]), 32'(e5[i]));
    check("d5_12_busy_end", 32'(capb5[2*nb5]), 32'd0);
    check("d5_count", 32'(fifo_count5), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
